// File: rtl/shift_pkg.sv
// Shared definitions for the parallel-to-serial shifter and its serial-to-parallel receiver.
package shift_pkg;

   localparam int SHIFT_WIDTH = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

endpackage

// File: rtl/shift_s_to_p_rx_if.sv
// Serial-in / word-out bundle of the receiver: shifter side inputs plus consumer handshake.
interface shift_s_to_p_rx_if #(
   parameter int WIDTH = shift_pkg::SHIFT_WIDTH
);
   logic             sIn;
   logic             start;
   logic             shiftEn;
   logic             ready;
   logic [WIDTH-1:0] dOut;
   logic             valid;
   logic             busy;
   logic             overrun;
   logic             frameErr;

   modport master (
      output sIn, start, shiftEn, ready,
      input  dOut, valid, busy, overrun, frameErr
   );

   modport slave (
      input  sIn, start, shiftEn, ready,
      output dOut, valid, busy, overrun, frameErr
   );
endinterface

// File: rtl/s2p_out_buffer.sv
// Single-entry holding register for received words with valid/ready handoff and sticky overrun.
module s2p_out_buffer #(
   parameter int WIDTH = shift_pkg::SHIFT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_overrun;
   logic             w_slot_free;

   // An acceptance on the same edge frees the slot for the incoming word.
   assign w_slot_free = !r_valid || i_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_push) begin
         if (w_slot_free) begin
            r_data  <= i_word;
            r_valid <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/shift_s_to_p_rx.sv
// Serial-to-parallel receiver: reassembles MSB-first frames from the upstream shifter into words.
module shift_s_to_p_rx
   import shift_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   shift_s_to_p_rx_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   rx_state_t        r_state;
   rx_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_sr;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_frame_err;
   logic [WIDTH:0]   w_ext;
   logic             w_take;
   logic             w_done;
   logic             w_busy;
   logic             w_unused_msb;
   logic [WIDTH-1:0] w_dout;
   logic             w_valid;
   logic             w_overrun;

   // The low WIDTH bits of {sr, sIn} are the word so far; the bit pushed out the top is dead.
   assign w_ext        = {r_sr, bus.sIn};
   assign w_unused_msb = w_ext[WIDTH];

   // start samples a bit in either state and overrides shiftEn.
   assign w_take    = bus.start || ((r_state == SHIFT) && bus.shiftEn);
   assign w_cnt_nxt = bus.start ? CNT_W'(1) : r_cnt + CNT_W'(1);
   assign w_done    = w_take && (w_cnt_nxt == CNT_W'(WIDTH));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = w_done ? IDLE : SHIFT;
         SHIFT:   if (w_done)    w_state_nxt = IDLE;
                  else if (bus.start) w_state_nxt = SHIFT;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      if (r_state == SHIFT) w_busy = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr        <= '0;
         r_cnt       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= (r_state == SHIFT) && bus.start;
         if (w_take) begin
            r_sr  <= w_ext[WIDTH-1:0];
            r_cnt <= w_done ? '0 : w_cnt_nxt;
         end
      end
   end

   s2p_out_buffer #(.WIDTH(WIDTH)) u_out_buf (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_push    (w_done),
      .i_word    (w_ext[WIDTH-1:0]),
      .i_ready   (bus.ready),
      .o_data    (w_dout),
      .o_valid   (w_valid),
      .o_overrun (w_overrun)
   );

   assign bus.dOut     = w_dout;
   assign bus.valid    = w_valid;
   assign bus.busy     = w_busy;
   assign bus.overrun  = w_overrun;
   assign bus.frameErr = r_frame_err;

endmodule
